// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift: receive-side bit unstuffer and byte assembler.
// Bits are assembled LSB-first. After six consecutive data ones, the next
// strobed bit is a stuffed bit and is dropped. Completed bytes are
// presented on rx_byte together with a one-cycle byte_valid pulse.
// An EOP that arrives while a byte is only partly assembled gives a
// one-cycle pulse on partial.
// Optional feature: define STUFF_ERR_EN to flag a 1 in a stuffed-bit
// position on the sticky stuff_error output. When the macro is undefined,
// stuff_error is tied to 0.
module rx_unstuff_shift (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_orig,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic       clear,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stuff_error,
  output logic       partial
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_valid_q, byte_valid_d;
  logic       partial_q, partial_d;

  // A bit sits in a stuffed position when the six bits before it were all ones.
  logic stuff_pos;
  assign stuff_pos = (ones_cnt_q == 3'd6);

  // Next-state logic. clear has priority over EOP, and EOP has priority over data.
  always_comb begin
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    partial_d    = 1'b0;
    if (clear) begin
      sr_d       = 8'h00;
      bit_cnt_d  = 3'd0;
      ones_cnt_d = 3'd0;
      rx_byte_d  = 8'h00;
    end else if (shift_enable && eop) begin
      sr_d       = 8'h00;
      bit_cnt_d  = 3'd0;
      ones_cnt_d = 3'd0;
      partial_d  = (bit_cnt_q != 3'd0);
    end else if (shift_enable) begin
      if (stuff_pos) begin
        // The stuffed bit is dropped. The byte position does not advance.
        ones_cnt_d = 3'd0;
      end else begin
        sr_d       = {d_orig, sr_q[7:1]};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        ones_cnt_d = d_orig ? (ones_cnt_q + 3'd1) : 3'd0;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d    = {d_orig, sr_q[7:1]};
          byte_valid_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr_q         <= 8'h00;
      bit_cnt_q    <= 3'd0;
      ones_cnt_q   <= 3'd0;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      partial_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      partial_q    <= partial_d;
    end
  end

`ifdef STUFF_ERR_EN
  logic stuff_error_q, stuff_error_d;

  // Sticky error flag: set by a 1 in a stuffed position, cleared only by clear or reset.
  always_comb begin
    stuff_error_d = stuff_error_q;
    if (clear) begin
      stuff_error_d = 1'b0;
    end else if (shift_enable && !eop && stuff_pos && d_orig) begin
      stuff_error_d = 1'b1;
    end
  end

  // Register for the sticky error flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stuff_error_q <= 1'b0;
    end else begin
      stuff_error_q <= stuff_error_d;
    end
  end

  assign stuff_error = stuff_error_q;
`else
  assign stuff_error = 1'b0;
`endif

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign partial    = partial_q;

endmodule
